// File: rtl/shift_add_mult_pkg.sv
// Shared definitions for the zero-skipping shift/add multiplier:
// operand width, FSM state encoding and the lowest-set-bit encoder.
package shift_add_mult_pkg;

    localparam int W = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Index of the lowest set bit; returns 0 when no bit is set.
    function automatic logic [3:0] lsb_index(input logic [W-1:0] v);
        logic [3:0] idx;
        idx = '0;
        for (int i = W - 1; i >= 0; i--) begin
            if (v[i]) idx = 4'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/shift_rotator.sv
// Combinational 16-bit barrel stage: logical shift left, or rotate left
// when rotate=1.
module shift_rotator
    import shift_add_mult_pkg::*;
(
    input  logic [W-1:0] src,
    input  logic [3:0]   amt,
    input  logic         rotate,
    output logic [W-1:0] res
);

    logic [2*W-1:0] wide;

    // Upper half of the doubled word shifted left is the left rotation.
    assign wide = {src, src} << amt;
    assign res  = rotate ? wide[2*W-1:W] : (src << amt);

endmodule

// File: rtl/shift_add_mult.sv
// Iterative unsigned 16x16->32 multiplier: one partial product per set bit
// of the multiplier, formed by two shift_rotator instances.
module shift_add_mult
    import shift_add_mult_pkg::*;
(
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
    output logic           busy,
    output logic           done,
    output logic [2*W-1:0] prod
);

    state_t         state, state_next;
    logic [W-1:0]   a_reg, mask, mask_next;
    logic [2*W-1:0] acc, acc_sum, pp;
    logic [3:0]     k;
    logic [W-1:0]   shl, rot;

    assign k = lsb_index(mask);

    shift_rotator u_shl (.src(a_reg), .amt(k), .rotate(1'b0), .res(shl));
    shift_rotator u_rot (.src(a_reg), .amt(k), .rotate(1'b1), .res(rot));

    // rot ^ shl isolates the bits wrapped around, i.e. a_reg >> (16-k).
    assign pp        = {rot ^ shl, shl};
    assign acc_sum   = acc + pp;
    assign mask_next = mask & (mask - 1'b1);

    // NOTE: every always_comb output gets a default first so no path leaves
    // it unassigned and no latch is inferred.
    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_next = (b != '0) ? RUN : DONE;
            end
            RUN: begin
                busy = 1'b1;
                if (mask_next == '0) state_next = DONE;
            end
            DONE: begin
                busy       = 1'b1;
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_reg <= '0;
            mask  <= '0;
            acc   <= '0;
            prod  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_reg <= a;
                        mask  <= b;
                        acc   <= '0;
                        // A zero multiplier completes without any RUN cycle.
                        if (b == '0) prod <= '0;
                    end
                end
                RUN: begin
                    acc  <= acc_sum;
                    mask <= mask_next;
                    if (mask_next == '0) prod <= acc_sum;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_shift_add_mult.sv
// Self-checking bench for shift_add_mult: directed vector table, corner
// sequences and a randomized sweep against an arithmetic reference.
module tb_shift_add_mult;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [15:0] a = '0;
    logic [15:0] b = '0;
    logic        busy;
    logic        done;
    logic [31:0] prod;

    int checks = 0;
    int errors = 0;

    localparam int TIMEOUT = 40;

    shift_add_mult dut (
        .clk  (clk),
        .rst_n(rst_n),
        .start(start),
        .a    (a),
        .b    (b),
        .busy (busy),
        .done (done),
        .prod (prod)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [31:0] p;
        int          cyc;
        int          busy_cyc;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] ref_prod(input logic [15:0] x, input logic [15:0] y);
        logic [31:0] xx, yy;
        xx = {16'd0, x};
        yy = {16'd0, y};
        return xx * yy;
    endfunction

    // Launch one operation; cyc = 1 + number of edges after the accept edge
    // before done is seen, busy_cyc = cycles with busy high.
    task automatic run_op(input logic [15:0] ta, input logic [15:0] tb_op,
                          output logic [31:0] p, output int cyc, output int busy_cyc);
        bit seen;
        @(negedge clk);
        a = ta; b = tb_op; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        a = 16'($urandom); b = 16'($urandom);
        cyc = 1; busy_cyc = 0; seen = 0; p = 'x;
        while (cyc <= TIMEOUT) begin
            @(negedge clk);
            if (busy) busy_cyc++;
            if (done) begin
                seen = 1;
                p = prod;
                break;
            end
            @(posedge clk);
            cyc++;
        end
        if (!seen) check("timeout", 32'd0, 32'd1);
        @(negedge clk);
        check("done_one_cycle", {30'd0, busy, done}, 32'd0);
    endtask

    vec_t        vecs[6];
    logic [31:0] p;
    int          cyc, bcyc;

    initial begin
        vecs[0] = '{16'd3,    16'd5,    32'h0000000F, 3,  3};
        vecs[1] = '{16'hFFFF, 16'hFFFF, 32'hFFFE0001, 17, 17};
        vecs[2] = '{16'h8000, 16'h8000, 32'h40000000, 2,  2};
        vecs[3] = '{16'h1234, 16'h0000, 32'h00000000, 1,  1};
        vecs[4] = '{16'h0000, 16'hFFFF, 32'h00000000, 17, 17};
        vecs[5] = '{16'hABCD, 16'h0001, 32'h0000ABCD, 2,  2};

        #12;
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_done", {31'd0, done}, 32'd0);
        check("reset_prod", prod, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 6; i++) begin
            run_op(vecs[i].a, vecs[i].b, p, cyc, bcyc);
            check($sformatf("vec%0d_prod", i), p, vecs[i].p);
            check($sformatf("vec%0d_latency", i), cyc, vecs[i].cyc);
            check($sformatf("vec%0d_busy", i), bcyc, vecs[i].busy_cyc);
        end

        // prod holds through IDLE and through the next operation's RUN phase.
        run_op(16'd3, 16'd5, p, cyc, bcyc);
        repeat (4) @(negedge clk);
        check("hold_idle", prod, 32'h0000000F);
        @(negedge clk);
        a = 16'hFFFF; b = 16'hFFFF; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (3) @(negedge clk);
        check("hold_run", prod, 32'h0000000F);
        repeat (20) @(negedge clk);
        check("after_hold_run", prod, 32'hFFFE0001);

        // start while busy is ignored; exactly one done pulse.
        begin
            int dones, first;
            dones = 0; first = 0;
            @(negedge clk);
            a = 16'hFFFF; b = 16'hFFFF; start = 1'b1;
            @(posedge clk);
            #1 start = 1'b0;
            for (int c = 1; c <= 30; c++) begin
                @(negedge clk);
                if (c == 5) begin
                    a = 16'd1; b = 16'd1; start = 1'b1;
                end else begin
                    start = 1'b0;
                end
                if (done) begin
                    dones++;
                    if (first == 0) first = c;
                end
            end
            start = 1'b0;
            check("busy_start_dones", dones, 32'd1);
            check("busy_start_latency", first, 32'd17);
            check("busy_start_prod", prod, 32'hFFFE0001);
        end

        // Reset in the fourth RUN cycle clears outputs at once.
        @(negedge clk);
        a = 16'hFFFF; b = 16'hFFFF; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_busy", {31'd0, busy}, 32'd0);
        check("midrst_done", {31'd0, done}, 32'd0);
        check("midrst_prod", prod, 32'd0);
        begin
            int dones;
            dones = 0;
            repeat (3) begin
                @(negedge clk);
                if (done) dones++;
            end
            rst_n = 1'b1;
            repeat (20) begin
                @(negedge clk);
                if (done) dones++;
            end
            check("midrst_no_done", dones, 32'd0);
        end
        run_op(16'd7, 16'd6, p, cyc, bcyc);
        check("post_rst_prod", p, 32'h0000002A);
        check("post_rst_latency", cyc, 32'd3);

        // Randomized sweep against the arithmetic reference.
        for (int n = 0; n < 2000; n++) begin
            logic [15:0] ra, rb;
            ra = 16'($urandom);
            rb = 16'($urandom);
            case (n % 8)
                0: rb = 16'd0;
                1: rb = 16'(1 << $urandom_range(15, 0));
                2: ra = 16'hFFFF;
                default: ;
            endcase
            run_op(ra, rb, p, cyc, bcyc);
            check($sformatf("rand%0d_prod a=%0h b=%0h", n, ra, rb), p, ref_prod(ra, rb));
            check($sformatf("rand%0d_latency", n), cyc, 32'($countones(rb) + 1));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
